async_fifo_write_arbiter: RTL and testbench
===========================================

Name: async_fifo_write_arbiter

Overview:
Round-robin arbiter sharing the single async FIFO write port among NUM_REQ requesters in the write clock domain. Each requester offers data with a valid/ready handshake. The arbiter grants one requester at a time for a burst of up to BURST_MAX beats and drives write_en/write_data into the FIFO. It never writes while write_full is high. It sits directly in front of the FIFO write side; the read side is untouched.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 8, FIFO data width; must equal `DATA_WIDTH
BURST_MAX, 4, max beats accepted per grant before forced re-arbitration (1..16)

Ports:
write_clk  input  1  write-domain clock
write_rst  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester data valid
req_data  input  NUM_REQ*DATA_WIDTH  packed requester data; slice i = requester i
req_ready  output  NUM_REQ  per-requester accept; one-hot or zero
write_en  output  1  FIFO write enable
write_data  output  DATA_WIDTH  FIFO write data
write_full  input  1  FIFO full flag (write domain)
grant_valid  output  1  a requester currently holds the grant
grant_id  output  $clog2(NUM_REQ)  index of current grant holder
beat_cnt  output  $clog2(BURST_MAX+1)  beats accepted in current grant

Behaviour:
- Reset (write_rst low, async): state IDLE, grant_valid=0, grant_id=0, beat_cnt=0, rr_ptr=0. With grant_valid=0, req_ready=0 and write_en=0 combinationally. write_data=0.
- States: IDLE (no grant), GRANT (grant_id owns the port). All state held in registers; clocked on posedge write_clk.
- Arbitration: search req_valid starting at rr_ptr, wrapping modulo NUM_REQ; first set bit wins. After reset requester 0 has top priority.
- IDLE -> GRANT when any req_valid: grant_id<=winner, beat_cnt<=0, rr_ptr<=winner+1 (mod NUM_REQ). Grant registers a cycle after the request; first beat can transfer the cycle after that.
- In GRANT, accept = req_valid[grant_id] & ~write_full (combinational). req_ready[grant_id]=~write_full; all other req_ready=0. write_en=accept; write_data=req_data slice grant_id whenever grant_valid, else 0. Zero latency from accept to FIFO write: same edge.
- Beat counting: beat_cnt increments on each accept. write_full high stalls; beat_cnt and grant are held; no beat lost or duplicated.
- Release conditions, evaluated each cycle in GRANT:
  (a) accept and beat_cnt==BURST_MAX-1 (burst limit), or
  (b) req_valid[grant_id]==0 (requester idle).
- On release, re-arbitrate in the same cycle from rr_ptr. If any other req_valid (or the same one under (a)) is set, go to GRANT with the new winner and beat_cnt<=0. Otherwise go to IDLE. Back-to-back handover costs no idle cycle.
- Under (a) the releasing requester has lowest priority, because rr_ptr already points past it. It regains the grant only if no other request is pending.
- Requester valid drops while write_full is high: release per (b). No write occurs.
- Simultaneous release and write_full: the last beat counts only if accept was true.
- Async reset mid-burst: grant is cleared immediately and the beat in flight is not written. Requesters must re-offer the beat.
- req_valid must stay asserted until req_ready (AXI-style); the arbiter does not check this.
- Widths: rr_ptr wraps via explicit compare to NUM_REQ-1, not power-of-two overflow.

Decomposition:
- Shared package async_fifo_pkg: DATA_WIDTH constant tied to `DATA_WIDTH, state enum arb_state_t {IDLE, GRANT}, REQ_IDX_W function/localparam.
- One sub-module: rr_priority_pick. It is combinational: inputs req vector and start pointer; outputs found and idx. It is instantiated once and reused for both the IDLE and handover decisions.
- Bench additions: extend async_fifo_interface with a write-arbiter modport and clocking block, using the same #1 skews.

Test Plan:
- Single requester: req 2 valid with data 0x10..0x15, write_full=0. Grant 2 on cycle 1; writes 0x10,0x11,0x12,0x13. Release after 4 beats, then re-grant 2 since it is alone; 0x14,0x15 follow after no idle cycle.
- All four valid continuously after reset. Grant order is 0,1,2,3,0, each holding exactly 4 beats. write_en is high every cycle after the first grant.
- Full stall: write_full high for 5 cycles mid-burst of req 1 at beat_cnt=2. write_en=0 and req_ready=0 during the stall; beat_cnt stays 2. Beats 3..4 then complete with no loss.
- Early release: req 3 drops valid after 1 beat while req 0 is pending. Handover to 0 on the next cycle with beat_cnt=0. rr_ptr wraps from 3 to 0 correctly.
- Reset mid-burst: assert write_rst low during beat 2 of req 1. Outputs go to 0 immediately. After release, req 0 is granted first when reqs 0 and 1 are both valid.
- Scoreboard: 1000 random beats from 4 requesters with random write_full. FIFO write stream equals the per-requester order interleaved per grant. No write occurs while write_full=1.

Source files
------------

// File: rtl/async_fifo_write_arbiter_pkg.sv
// Shared definitions for the async FIFO write-side arbiter.
//   DATA_WIDTH  : FIFO data width, taken from the `DATA_WIDTH macro (8 if undefined)
//   arb_state_t : arbiter state encoding
//   req_idx_w() : width of a requester index for a given requester count
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

package async_fifo_pkg;

   localparam int DATA_WIDTH = `DATA_WIDTH;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   function automatic int req_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/async_fifo_write_arbiter_pick.sv
// Round-robin priority picker (combinational).
//   i_req   : request vector
//   i_start : index with highest priority; the search wraps modulo NUM_REQ
//   o_found : at least one request is set
//   o_idx   : first set request at or after i_start
module rr_priority_pick
   import async_fifo_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   localparam int IDX_W   = req_idx_w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDX_W-1:0]   i_start,
   output logic               o_found,
   output logic [IDX_W-1:0]   o_idx
);

   logic [IDX_W-1:0] w_cand;

   // The candidate walks start, start+1, ... with an explicit wrap so that
   // non-power-of-two requester counts never index past NUM_REQ-1.
   always_comb begin
      o_found = 1'b0;
      o_idx   = '0;
      w_cand  = i_start;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!o_found && i_req[w_cand]) begin
            o_found = 1'b1;
            o_idx   = w_cand;
         end
         w_cand = (w_cand == IDX_W'(NUM_REQ - 1)) ? '0 : w_cand + 1'b1;
      end
   end

endmodule

// File: rtl/async_fifo_write_arbiter.sv
// Round-robin arbiter sharing one async FIFO write port among NUM_REQ
// requesters in the write clock domain.
//   write_clk / write_rst : write clock, async active-low reset
//   req_valid / req_data  : per-requester offer (slice i = requester i)
//   req_ready             : accept strobe, one-hot or zero
//   write_en / write_data : FIFO write port; write_full blocks all writes
//   grant_valid / grant_id: current grant holder
//   beat_cnt              : beats accepted in the current grant
//
// state | meaning
// IDLE  | no requester holds the port
// GRANT | grant_id owns the port for up to BURST_MAX beats
module async_fifo_write_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = async_fifo_pkg::DATA_WIDTH,
   parameter int BURST_MAX  = 4
) (
   input  logic                            write_clk,
   input  logic                            write_rst,
   input  logic [NUM_REQ-1:0]              req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
   output logic [NUM_REQ-1:0]              req_ready,
   output logic                            write_en,
   output logic [DATA_WIDTH-1:0]           write_data,
   input  logic                            write_full,
   output logic                            grant_valid,
   output logic [$clog2(NUM_REQ)-1:0]      grant_id,
   output logic [$clog2(BURST_MAX+1)-1:0]  beat_cnt
);

   import async_fifo_pkg::*;

   localparam int IDX_W = req_idx_w(NUM_REQ);
   localparam int BCW   = $clog2(BURST_MAX + 1);
   localparam logic [BCW-1:0] LAST_BEAT = BCW'(BURST_MAX - 1);

   arb_state_t       r_state;
   logic             r_grant_valid;
   logic [IDX_W-1:0] r_grant_id;
   logic [IDX_W-1:0] r_rr_ptr;
   logic [BCW-1:0]   r_beat_cnt;

   logic             w_owner_valid;
   logic             w_accept;
   logic             w_release;
   logic             w_pick_found;
   logic [IDX_W-1:0] w_pick_idx;
   logic [IDX_W-1:0] w_next_ptr;

   assign w_owner_valid = req_valid[r_grant_id];
   assign w_accept      = r_grant_valid & w_owner_valid & ~write_full;
   assign w_release     = (w_accept & (r_beat_cnt == LAST_BEAT)) | ~w_owner_valid;

   // One picker serves both the IDLE decision and the handover. On a burst
   // release rr_ptr already points past the holder, so it naturally ends up
   // with the lowest priority; on an idle release its valid is low.
   rr_priority_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_pick (
      .i_req   (req_valid),
      .i_start (r_rr_ptr),
      .o_found (w_pick_found),
      .o_idx   (w_pick_idx)
   );

   assign w_next_ptr = (w_pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_pick_idx + 1'b1;

   always_comb begin
      req_ready = '0;
      if (r_grant_valid) begin
         req_ready[r_grant_id] = ~write_full;
      end
   end

   assign write_en   = w_accept;
   assign write_data = r_grant_valid ? req_data[r_grant_id*DATA_WIDTH +: DATA_WIDTH] : '0;

   always_ff @(posedge write_clk or negedge write_rst) begin
      if (!write_rst) begin
         r_state       <= IDLE;
         r_grant_valid <= 1'b0;
         r_grant_id    <= '0;
         r_rr_ptr      <= '0;
         r_beat_cnt    <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_pick_found) begin
                  r_state       <= GRANT;
                  r_grant_valid <= 1'b1;
                  r_grant_id    <= w_pick_idx;
                  r_rr_ptr      <= w_next_ptr;
                  r_beat_cnt    <= '0;
               end
            end
            GRANT: begin
               if (w_release) begin
                  r_beat_cnt <= '0;
                  if (w_pick_found) begin
                     r_grant_id <= w_pick_idx;
                     r_rr_ptr   <= w_next_ptr;
                  end else begin
                     r_state       <= IDLE;
                     r_grant_valid <= 1'b0;
                  end
               end else if (w_accept) begin
                  r_beat_cnt <= r_beat_cnt + 1'b1;
               end
            end
            default: begin
               r_state       <= IDLE;
               r_grant_valid <= 1'b0;
            end
         endcase
      end
   end

   assign grant_valid = r_grant_valid;
   assign grant_id    = r_grant_id;
   assign beat_cnt    = r_beat_cnt;

endmodule

// File: tb/tb_async_fifo_write_arbiter.sv
module tb_async_fifo_write_arbiter;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int BM = 4;

   logic            write_clk = 1'b0;
   logic            write_rst;
   logic [N-1:0]    req_valid;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    req_ready;
   logic            write_en;
   logic [DW-1:0]   write_data;
   logic            write_full;
   logic            grant_valid;
   logic [1:0]      grant_id;
   logic [2:0]      beat_cnt;

   async_fifo_write_arbiter #(
      .NUM_REQ    (N),
      .DATA_WIDTH (DW),
      .BURST_MAX  (BM)
   ) dut (
      .write_clk   (write_clk),
      .write_rst   (write_rst),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .write_en    (write_en),
      .write_data  (write_data),
      .write_full  (write_full),
      .grant_valid (grant_valid),
      .grant_id    (grant_id),
      .beat_cnt    (beat_cnt)
   );

   always #5 write_clk = ~write_clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic set_data(input int base);
      for (int i = 0; i < N; i++) req_data[i*DW +: DW] = DW'(base + i);
   endtask

   task automatic step();
      @(posedge write_clk);
      #1;
   endtask

   task automatic do_reset();
      req_valid  = '0;
      write_full = 1'b0;
      set_data(0);
      write_rst  = 1'b0;
      repeat (2) @(posedge write_clk);
      @(negedge write_clk);
      chk("rst_grant_valid", 32'(grant_valid), 0);
      chk("rst_grant_id", 32'(grant_id), 0);
      chk("rst_beat_cnt", 32'(beat_cnt), 0);
      chk("rst_write_en", 32'(write_en), 0);
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_write_data", 32'(write_data), 0);
      write_rst = 1'b1;
      step();
   endtask

   // ---------------- behavioural reference model ----------------
   int m_owner;   // -1 when nobody holds the port
   int m_cnt;
   int m_next;    // requester searched first at the next decision

   function automatic int m_pick(input logic [N-1:0] v, input int start);
      for (int k = 0; k < N; k++)
         if (v[(start + k) % N]) return (start + k) % N;
      return -1;
   endfunction

   task automatic m_take_next(input logic [N-1:0] v);
      int w;
      w = m_pick(v, m_next);
      if (w >= 0) begin
         m_owner = w;
         m_cnt   = 0;
         m_next  = (w + 1) % N;
      end else begin
         m_owner = -1;
         m_cnt   = 0;
      end
   endtask

   task automatic m_update(input logic [N-1:0] v, input bit took);
      if (m_owner < 0) begin
         m_take_next(v);
      end else begin
         if (took) m_cnt++;
         if ((took && m_cnt == BM) || !v[m_owner]) m_take_next(v);
      end
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic [3:0] valid;
      logic       full;
      logic       gv;
      int         gid;
      int         beat;
      logic       en;
      logic [3:0] ready;
   } vec_t;

   vec_t tbl[16];

   initial begin
      logic [N-1:0] v;
      int           seq[N];
      int           acc;
      int           beats;
      int           cyc;
      bit           full;
      bit           e_gv;
      bit           e_en;
      logic [N-1:0] e_ready;

      tbl[0]  = '{4'b0100, 1'b0, 1'b0, 0, 0, 1'b0, 4'b0000};
      tbl[1]  = '{4'b0100, 1'b0, 1'b1, 2, 0, 1'b1, 4'b0100};
      tbl[2]  = '{4'b0100, 1'b0, 1'b1, 2, 1, 1'b1, 4'b0100};
      tbl[3]  = '{4'b0100, 1'b0, 1'b1, 2, 2, 1'b1, 4'b0100};
      tbl[4]  = '{4'b0100, 1'b0, 1'b1, 2, 3, 1'b1, 4'b0100};
      tbl[5]  = '{4'b0100, 1'b0, 1'b1, 2, 0, 1'b1, 4'b0100};
      tbl[6]  = '{4'b0001, 1'b0, 1'b1, 2, 1, 1'b0, 4'b0100};
      tbl[7]  = '{4'b1001, 1'b0, 1'b1, 0, 0, 1'b1, 4'b0001};
      tbl[8]  = '{4'b1001, 1'b1, 1'b1, 0, 1, 1'b0, 4'b0000};
      tbl[9]  = '{4'b1001, 1'b0, 1'b1, 0, 1, 1'b1, 4'b0001};
      tbl[10] = '{4'b1000, 1'b0, 1'b1, 0, 2, 1'b0, 4'b0001};
      tbl[11] = '{4'b1001, 1'b0, 1'b1, 3, 0, 1'b1, 4'b1000};
      tbl[12] = '{4'b0001, 1'b0, 1'b1, 3, 1, 1'b0, 4'b1000};
      tbl[13] = '{4'b0001, 1'b0, 1'b1, 0, 0, 1'b1, 4'b0001};
      tbl[14] = '{4'b0000, 1'b0, 1'b1, 0, 1, 1'b0, 4'b0001};
      tbl[15] = '{4'b0000, 1'b0, 1'b0, 0, 0, 1'b0, 4'b0000};

      write_rst = 1'b0;
      do_reset();
      set_data(8'hA0);
      for (int i = 0; i < 16; i++) begin
         req_valid  = tbl[i].valid;
         write_full = tbl[i].full;
         @(negedge write_clk);
         chk($sformatf("tbl%0d_grant_valid", i), 32'(grant_valid), 32'(tbl[i].gv));
         chk($sformatf("tbl%0d_write_en", i), 32'(write_en), 32'(tbl[i].en));
         chk($sformatf("tbl%0d_req_ready", i), 32'(req_ready), 32'(tbl[i].ready));
         chk($sformatf("tbl%0d_write_data", i), 32'(write_data),
             tbl[i].gv ? 32'(8'hA0 + tbl[i].gid) : 32'd0);
         if (tbl[i].gv) begin
            chk($sformatf("tbl%0d_grant_id", i), 32'(grant_id), 32'(tbl[i].gid));
            chk($sformatf("tbl%0d_beat_cnt", i), 32'(beat_cnt), 32'(tbl[i].beat));
         end
         step();
      end

      // ---- all four valid: grants 0,1,2,3,0 with 4 beats each, no gap ----
      do_reset();
      set_data(8'hA0);
      req_valid = 4'b1111;
      @(negedge write_clk);
      chk("rr_idle_first_cycle", 32'(write_en), 0);
      for (int k = 0; k < 17; k++) begin
         step();
         @(negedge write_clk);
         chk($sformatf("rr_en_%0d", k), 32'(write_en), 1);
         chk($sformatf("rr_gid_%0d", k), 32'(grant_id), 32'((k / BM) % N));
         chk($sformatf("rr_beat_%0d", k), 32'(beat_cnt), 32'(k % BM));
      end
      step();

      // ---- full stall of 5 cycles at beat_cnt=2 of requester 1 ----
      do_reset();
      set_data(8'h30);
      req_valid = 4'b0010;
      repeat (3) step();
      write_full = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge write_clk);
         chk($sformatf("stall_en_%0d", k), 32'(write_en), 0);
         chk($sformatf("stall_ready_%0d", k), 32'(req_ready), 0);
         chk($sformatf("stall_beat_%0d", k), 32'(beat_cnt), 2);
         step();
      end
      write_full = 1'b0;
      @(negedge write_clk);
      chk("stall_resume_beat2_en", 32'(write_en), 1);
      chk("stall_resume_beat2_cnt", 32'(beat_cnt), 2);
      step();
      @(negedge write_clk);
      chk("stall_resume_beat3_en", 32'(write_en), 1);
      chk("stall_resume_beat3_cnt", 32'(beat_cnt), 3);
      step();
      @(negedge write_clk);
      chk("stall_regrant_gid", 32'(grant_id), 1);
      chk("stall_regrant_cnt", 32'(beat_cnt), 0);
      step();

      // ---- async reset mid-burst, then requester 0 wins first ----
      do_reset();
      set_data(8'h20);
      req_valid = 4'b0010;
      repeat (3) step();
      chk("midrst_pre_beat", 32'(beat_cnt), 2);
      chk("midrst_pre_en", 32'(write_en), 1);
      #2;
      write_rst = 1'b0;
      #1;
      chk("midrst_grant_valid", 32'(grant_valid), 0);
      chk("midrst_write_en", 32'(write_en), 0);
      chk("midrst_req_ready", 32'(req_ready), 0);
      chk("midrst_write_data", 32'(write_data), 0);
      chk("midrst_beat_cnt", 32'(beat_cnt), 0);
      req_valid = 4'b0011;
      step();
      write_rst = 1'b1;
      step();
      @(negedge write_clk);
      chk("midrst_after_gv", 32'(grant_valid), 1);
      chk("midrst_after_gid", 32'(grant_id), 0);
      step();

      // ---- random traffic against the reference model ----
      do_reset();
      m_owner = -1;
      m_cnt   = 0;
      m_next  = 0;
      v       = '0;
      for (int i = 0; i < N; i++) seq[i] = 0;
      acc   = -1;
      beats = 0;
      cyc   = 0;
      while (beats < 1000 && cyc < 20000) begin
         for (int i = 0; i < N; i++) begin
            if (i == acc) begin
               seq[i]++;
               v[i] = ($urandom_range(3) != 0);
            end else if (!v[i]) begin
               v[i] = 1'($urandom_range(1));
            end
            req_data[i*DW +: DW] = {2'(i), 6'(seq[i])};
         end
         full       = ($urandom_range(3) == 0);
         req_valid  = v;
         write_full = full;
         @(negedge write_clk);

         e_gv    = (m_owner >= 0);
         e_en    = 1'b0;
         e_ready = '0;
         if (e_gv) begin
            e_en = v[m_owner] && !full;
            if (!full) e_ready = N'(1 << m_owner);
         end
         chk("rnd_grant_valid", 32'(grant_valid), 32'(e_gv));
         chk("rnd_write_en", 32'(write_en), 32'(e_en));
         chk("rnd_req_ready", 32'(req_ready), 32'(e_ready));
         chk("rnd_no_write_when_full", 32'(write_en & write_full), 0);
         if (e_gv) begin
            chk("rnd_grant_id", 32'(grant_id), 32'(m_owner));
            chk("rnd_beat_cnt", 32'(beat_cnt), 32'(m_cnt));
         end
         if (e_en) begin
            chk("rnd_write_data", 32'(write_data), 32'({2'(m_owner), 6'(seq[m_owner])}));
            beats++;
         end
         acc = e_en ? m_owner : -1;
         m_update(v, e_en);
         step();
         cyc++;
      end
      chk("rnd_beats_completed", 32'(beats >= 1000), 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
